// File: rtl/ext_cpu_obi_arbiter_if.sv
// OBI bundle for the hart-side ports and the shared slave-side port of ext_cpu_obi_arbiter.
// Handshake: an address phase completes on the cycle req and gnt are both high, and the
// master must hold req and its address fields stable until then. rvalid is a one-cycle
// response pulse with no backpressure, and responses return in grant order.
interface ext_cpu_obi_arbiter_if #(
    parameter int NHARTS = 2
);
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    obi_req_t  [NHARTS-1:0] master_req_i;
    obi_resp_t [NHARTS-1:0] master_resp_o;
    obi_req_t               slave_req_o;
    obi_resp_t              slave_resp_i;

    modport slave (
        input  master_req_i,
        output master_resp_o,
        output slave_req_o,
        input  slave_resp_i
    );

    modport master (
        output master_req_i,
        input  master_resp_o,
        input  slave_req_o,
        output slave_resp_i
    );
endinterface

// File: rtl/ext_cpu_obi_arbiter.sv
// Round-robin OBI arbiter: NHARTS masters share one in-order slave port. Grants are locked
// while an address phase waits, and responses are steered back through a FIFO of winners.
module ext_cpu_obi_arbiter #(
    parameter int NHARTS          = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    ext_cpu_obi_arbiter_if.slave                 bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o,
    output logic                                 lock_state_o
);
    localparam int IW = (NHARTS > 1) ? $clog2(NHARTS) : 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e state_q, state_d;
    logic [IW-1:0] locked_idx_q, locked_idx_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          err_q;

    logic [IW-1:0] winner;
    logic [IW-1:0] cand_idx;
    logic [IW-1:0] head;
    int            cand;
    logic          any_req, full, empty, fwd, hs, push, pop;

    assign full  = (count_q == CW'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);
    assign head  = fifo_mem[rd_ptr_q];

    // Search starts at rr_ptr; iterating from the far end lets the nearest requester win.
    always_comb begin
        winner   = rr_ptr_q;
        any_req  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        if (state_q == ST_LOCKED) begin
            winner  = locked_idx_q;
            any_req = bus.master_req_i[locked_idx_q].req;
        end else begin
            for (int k = NHARTS - 1; k >= 0; k--) begin
                cand = int'(rr_ptr_q) + k;
                if (cand >= NHARTS) cand = cand - NHARTS;
                cand_idx = IW'(cand);
                if (bus.master_req_i[cand_idx].req) begin
                    winner  = cand_idx;
                    any_req = 1'b1;
                end
            end
        end
    end

    assign fwd  = any_req & ~full;
    assign hs   = fwd & bus.slave_resp_i.gnt;
    assign push = hs;
    assign pop  = bus.slave_resp_i.rvalid & ~empty;

    always_comb begin
        bus.slave_req_o     = bus.master_req_i[winner];
        bus.slave_req_o.req = fwd;
        bus.master_resp_o   = '0;
        for (int i = 0; i < NHARTS; i++) begin
            bus.master_resp_o[i].rdata  = bus.slave_resp_i.rdata;
            bus.master_resp_o[i].gnt    = hs && (winner == IW'(i));
            bus.master_resp_o[i].rvalid = pop && (head == IW'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        locked_idx_d = locked_idx_q;
        rr_ptr_d     = rr_ptr_q;
        case (state_q)
            ST_OPEN: begin
                if (fwd && !bus.slave_resp_i.gnt) begin
                    state_d      = ST_LOCKED;
                    locked_idx_d = winner;
                end
            end
            ST_LOCKED: begin
                if (hs) state_d = ST_OPEN;
            end
            default: state_d = ST_OPEN;
        endcase
        if (hs) rr_ptr_d = (winner == IW'(NHARTS - 1)) ? '0 : winner + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_OPEN;
            locked_idx_q <= '0;
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            locked_idx_q <= locked_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            if (push) wr_ptr_q <= (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (bus.slave_resp_i.rvalid && empty) err_q <= 1'b1;
        end
    end

    // Entries hold only routing indices; stale contents are never read past count_q.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= winner;
    end

    assign outstanding_o = count_q;
    assign err_o         = err_q;
    assign lock_state_o  = (state_q == ST_LOCKED);
endmodule

// File: tb/tb_ext_cpu_obi_arbiter.sv
// Directed bench for ext_cpu_obi_arbiter: single master, round-robin, lock, full FIFO,
// spurious response and asynchronous reset, with hand-computed expectations.
module tb_ext_cpu_obi_arbiter;
    localparam int NHARTS = 2;
    localparam int MAXO   = 2;

    logic       clk;
    logic       rst_n;
    logic [1:0] outstanding;
    logic       err;
    logic       lock_state;
    int         checks;
    int         errors;

    ext_cpu_obi_arbiter_if #(.NHARTS(NHARTS)) bus ();

    ext_cpu_obi_arbiter #(.NHARTS(NHARTS), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .bus          (bus),
        .outstanding_o(outstanding),
        .err_o        (err),
        .lock_state_o (lock_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic r, input logic [31:0] a);
        if (m == 0) begin
            bus.master_req_i[0].req   = r;
            bus.master_req_i[0].addr  = a;
            bus.master_req_i[0].we    = 1'b0;
            bus.master_req_i[0].be    = 4'hf;
            bus.master_req_i[0].wdata = 32'h0;
        end else begin
            bus.master_req_i[1].req   = r;
            bus.master_req_i[1].addr  = a;
            bus.master_req_i[1].we    = 1'b0;
            bus.master_req_i[1].be    = 4'hf;
            bus.master_req_i[1].wdata = 32'h0;
        end
    endtask

    task automatic slv(input logic g, input logic rv, input logic [31:0] d);
        bus.slave_resp_i.gnt    = g;
        bus.slave_resp_i.rvalid = rv;
        bus.slave_resp_i.rdata  = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(0, 1'b0, 32'h0);
        drive(1, 1'b0, 32'h0);
        slv(1'b0, 1'b0, 32'h0);
        #1;
        chk("rst_outst", 32'(outstanding), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_sreq", 32'(bus.slave_req_o.req), 0);
        chk("rst_gnt0", 32'(bus.master_resp_o[0].gnt), 0);
        chk("rst_lock", 32'(lock_state), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // single master, three back-to-back reads
        drive(0, 1'b1, 32'h1000); slv(1'b1, 1'b0, 32'h0); #1;
        chk("t1c0_gnt0", 32'(bus.master_resp_o[0].gnt), 1);
        chk("t1c0_gnt1", 32'(bus.master_resp_o[1].gnt), 0);
        chk("t1c0_saddr", bus.slave_req_o.addr, 32'h1000);
        tick();
        drive(0, 1'b1, 32'h1004); slv(1'b1, 1'b1, 32'hD000_0000); #1;
        chk("t1c1_gnt0", 32'(bus.master_resp_o[0].gnt), 1);
        chk("t1c1_rv0", 32'(bus.master_resp_o[0].rvalid), 1);
        chk("t1c1_rdata", bus.master_resp_o[0].rdata, 32'hD000_0000);
        chk("t1c1_rv1", 32'(bus.master_resp_o[1].rvalid), 0);
        chk("t1c1_outst", 32'(outstanding), 1);
        tick();
        drive(0, 1'b1, 32'h1008); slv(1'b1, 1'b1, 32'hD000_0001); #1;
        chk("t1c2_saddr", bus.slave_req_o.addr, 32'h1008);
        chk("t1c2_rdata", bus.master_resp_o[0].rdata, 32'hD000_0001);
        chk("t1c2_outst", 32'(outstanding), 1);
        tick();
        drive(0, 1'b0, 32'h0); slv(1'b0, 1'b1, 32'hD000_0002); #1;
        chk("t1c3_sreq", 32'(bus.slave_req_o.req), 0);
        chk("t1c3_rv0", 32'(bus.master_resp_o[0].rvalid), 1);
        chk("t1c3_rv1", 32'(bus.master_resp_o[1].rvalid), 0);
        tick();
        slv(1'b0, 1'b0, 32'h0); #1;
        chk("t1c4_outst", 32'(outstanding), 0);
        chk("t1c4_rv0", 32'(bus.master_resp_o[0].rvalid), 0);

        // reset so round-robin starts at master0
        rst_n = 1'b0; #1;
        chk("t2_rst_outst", 32'(outstanding), 0);
        tick();
        rst_n = 1'b1;
        drive(0, 1'b1, 32'h2000); drive(1, 1'b1, 32'h3000); slv(1'b1, 1'b0, 32'h0); #1;
        chk("t2c0_gnt0", 32'(bus.master_resp_o[0].gnt), 1);
        chk("t2c0_gnt1", 32'(bus.master_resp_o[1].gnt), 0);
        tick();
        slv(1'b1, 1'b1, 32'hA0); #1;
        chk("t2c1_gnt0", 32'(bus.master_resp_o[0].gnt), 0);
        chk("t2c1_gnt1", 32'(bus.master_resp_o[1].gnt), 1);
        chk("t2c1_saddr", bus.slave_req_o.addr, 32'h3000);
        chk("t2c1_rv0", 32'(bus.master_resp_o[0].rvalid), 1);
        chk("t2c1_rv1", 32'(bus.master_resp_o[1].rvalid), 0);
        tick();
        slv(1'b1, 1'b1, 32'hA1); #1;
        chk("t2c2_gnt0", 32'(bus.master_resp_o[0].gnt), 1);
        chk("t2c2_gnt1", 32'(bus.master_resp_o[1].gnt), 0);
        chk("t2c2_rv1", 32'(bus.master_resp_o[1].rvalid), 1);
        chk("t2c2_rv0", 32'(bus.master_resp_o[0].rvalid), 0);
        tick();
        slv(1'b1, 1'b1, 32'hA2); #1;
        chk("t2c3_gnt1", 32'(bus.master_resp_o[1].gnt), 1);
        chk("t2c3_gnt0", 32'(bus.master_resp_o[0].gnt), 0);
        chk("t2c3_rv0", 32'(bus.master_resp_o[0].rvalid), 1);
        tick();
        drive(0, 1'b0, 32'h0); drive(1, 1'b0, 32'h0); slv(1'b0, 1'b1, 32'hA3); #1;
        chk("t2c4_rv1", 32'(bus.master_resp_o[1].rvalid), 1);
        chk("t2c4_sreq", 32'(bus.slave_req_o.req), 0);
        tick();
        slv(1'b0, 1'b0, 32'h0); #1;
        chk("t2c5_outst", 32'(outstanding), 0);

        // lock: master1 waits three cycles, master0 arrives during the wait
        drive(1, 1'b1, 32'h4000); slv(1'b0, 1'b0, 32'h0); #1;
        chk("t3c0_sreq", 32'(bus.slave_req_o.req), 1);
        chk("t3c0_saddr", bus.slave_req_o.addr, 32'h4000);
        chk("t3c0_gnt1", 32'(bus.master_resp_o[1].gnt), 0);
        tick();
        drive(0, 1'b1, 32'h5000); #1;
        chk("t3c1_saddr", bus.slave_req_o.addr, 32'h4000);
        chk("t3c1_gnt0", 32'(bus.master_resp_o[0].gnt), 0);
        chk("t3c1_lock", 32'(lock_state), 1);
        tick();
        #1;
        chk("t3c2_saddr", bus.slave_req_o.addr, 32'h4000);
        tick();
        slv(1'b1, 1'b0, 32'h0); #1;
        chk("t3c3_gnt1", 32'(bus.master_resp_o[1].gnt), 1);
        chk("t3c3_gnt0", 32'(bus.master_resp_o[0].gnt), 0);
        chk("t3c3_saddr", bus.slave_req_o.addr, 32'h4000);
        tick();
        drive(1, 1'b0, 32'h0); #1;
        chk("t3c4_gnt0", 32'(bus.master_resp_o[0].gnt), 1);
        chk("t3c4_saddr", bus.slave_req_o.addr, 32'h5000);
        chk("t3c4_outst", 32'(outstanding), 1);
        chk("t3c4_lock", 32'(lock_state), 0);
        tick();
        drive(0, 1'b0, 32'h0); slv(1'b0, 1'b1, 32'hB1); #1;
        chk("t3c5_rv1", 32'(bus.master_resp_o[1].rvalid), 1);
        chk("t3c5_rv0", 32'(bus.master_resp_o[0].rvalid), 0);
        chk("t3c5_outst", 32'(outstanding), 2);
        tick();
        slv(1'b0, 1'b1, 32'hB0); #1;
        chk("t3c6_rv0", 32'(bus.master_resp_o[0].rvalid), 1);
        chk("t3c6_rv1", 32'(bus.master_resp_o[1].rvalid), 0);
        tick();
        slv(1'b0, 1'b0, 32'h0); #1;
        chk("t3c7_outst", 32'(outstanding), 0);

        // full FIFO blocks issue; a same-cycle pop does not unblock
        drive(0, 1'b1, 32'h6000); slv(1'b1, 1'b0, 32'h0); #1;
        chk("t4c0_gnt0", 32'(bus.master_resp_o[0].gnt), 1);
        tick();
        #1;
        chk("t4c1_gnt0", 32'(bus.master_resp_o[0].gnt), 1);
        chk("t4c1_outst", 32'(outstanding), 1);
        tick();
        #1;
        chk("t4c2_sreq", 32'(bus.slave_req_o.req), 0);
        chk("t4c2_gnt0", 32'(bus.master_resp_o[0].gnt), 0);
        chk("t4c2_outst", 32'(outstanding), 2);
        tick();
        slv(1'b1, 1'b1, 32'hC0); #1;
        chk("t4c3_sreq", 32'(bus.slave_req_o.req), 0);
        chk("t4c3_gnt0", 32'(bus.master_resp_o[0].gnt), 0);
        chk("t4c3_rv0", 32'(bus.master_resp_o[0].rvalid), 1);
        tick();
        slv(1'b1, 1'b0, 32'h0); #1;
        chk("t4c4_sreq", 32'(bus.slave_req_o.req), 1);
        chk("t4c4_gnt0", 32'(bus.master_resp_o[0].gnt), 1);
        chk("t4c4_outst", 32'(outstanding), 1);
        tick();
        drive(0, 1'b0, 32'h0); slv(1'b0, 1'b1, 32'hC1); #1;
        chk("t4c5_outst", 32'(outstanding), 2);
        chk("t4c5_rv0", 32'(bus.master_resp_o[0].rvalid), 1);
        tick();
        slv(1'b0, 1'b1, 32'hC2); #1;
        chk("t4c6_outst", 32'(outstanding), 1);
        tick();
        slv(1'b0, 1'b0, 32'h0); #1;
        chk("t4c7_outst", 32'(outstanding), 0);
        chk("t4c7_err", 32'(err), 0);

        // spurious rvalid, then asynchronous reset with a transaction in flight
        drive(0, 1'b1, 32'h7000); slv(1'b1, 1'b0, 32'h0); #1;
        chk("t5c0_gnt0", 32'(bus.master_resp_o[0].gnt), 1);
        tick();
        drive(0, 1'b0, 32'h0); slv(1'b0, 1'b1, 32'hE0); #1;
        chk("t5c1_rv0", 32'(bus.master_resp_o[0].rvalid), 1);
        tick();
        slv(1'b0, 1'b1, 32'hE1); #1;
        chk("t5c2_rv0", 32'(bus.master_resp_o[0].rvalid), 0);
        chk("t5c2_rv1", 32'(bus.master_resp_o[1].rvalid), 0);
        chk("t5c2_err", 32'(err), 0);
        tick();
        slv(1'b0, 1'b0, 32'h0); #1;
        chk("t5c3_err", 32'(err), 1);
        chk("t5c3_outst", 32'(outstanding), 0);
        tick();
        drive(0, 1'b1, 32'h7004); slv(1'b1, 1'b0, 32'h0); #1;
        chk("t5c4_gnt0", 32'(bus.master_resp_o[0].gnt), 1);
        chk("t5c4_err", 32'(err), 1);
        tick();
        drive(0, 1'b0, 32'h0); slv(1'b0, 1'b0, 32'h0); #1;
        chk("t5c5_outst", 32'(outstanding), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_arst_err", 32'(err), 0);
        chk("t5_arst_outst", 32'(outstanding), 0);
        tick();
        rst_n = 1'b1;
        drive(0, 1'b1, 32'h8000); drive(1, 1'b1, 32'h9000); slv(1'b1, 1'b0, 32'h0); #1;
        chk("t5c6_gnt0", 32'(bus.master_resp_o[0].gnt), 1);
        chk("t5c6_gnt1", 32'(bus.master_resp_o[1].gnt), 0);
        chk("t5c6_saddr", bus.slave_req_o.addr, 32'h8000);
        tick();
        drive(0, 1'b0, 32'h0); drive(1, 1'b0, 32'h0); slv(1'b0, 1'b0, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
